pe_row_scheduler: RTL and testbench

Sequencer for the sparse-convolution PE row pipeline. It loads the filter bank once per frame, then walks the compressed input-feature memory row by row. For each row it reads a header word (non-zero count) and streams that many entries to the PE with a running position count. It closes every row with a zero flush beat and a `row_fini` pulse, and advances the output-memory write pointer by the PE pop count. It replaces the free-running counters around the PE with one explicit FSM and a start/done handshake.

---
 rtl/pe_pkg.sv | 30 +++
 rtl/pe_row_scheduler_ptr.sv | 58 +++++
 rtl/pe_row_scheduler.sv | 164 ++++++++++++++++
 tb/tb_pe_row_scheduler.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the sparse-convolution PE row pipeline:
// sequencer states, input word field layout and default geometry.
package pe_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_HDR    = 3'd2,
    S_HCAP   = 3'd3,
    S_STREAM = 3'd4,
    S_FLUSH  = 3'd5,
    S_FIN    = 3'd6
  } state_e;

  localparam int IDX_HI = 15;
  localparam int IDX_LO = 8;
  localparam int VAL_HI = 7;

  localparam int ROW_LEN_DEF     = 28;
  localparam int FILTER_SIZE_DEF = 5;

  function automatic logic [7:0] word_index(input logic [15:0] w);
    return w[IDX_HI:IDX_LO];
  endfunction

  function automatic logic [7:0] word_value(input logic [15:0] w);
    return w[VAL_HI:0];
  endfunction

endpackage

// File: rtl/pe_row_scheduler_ptr.sv
// Output-memory write pointer and sticky error flag: clamps the PE pop count,
// adds a full filter stride on every row flush.
module pe_row_scheduler_ptr
  import pe_pkg::*;
#(
  parameter int OUT_ADDR_W  = 5,
  parameter int FILTER_SIZE = FILTER_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  stream_i,
  input  logic                  flush_i,
  input  logic                  sat_err_i,
  input  logic [2:0]            pop_i,
  output logic                  out_we_o,
  output logic [OUT_ADDR_W-1:0] out_addr_o,
  output logic                  err_o
);

  localparam logic [2:0]            POP_MAX    = 3'(FILTER_SIZE);
  localparam logic [OUT_ADDR_W-1:0] FLUSH_STEP = OUT_ADDR_W'(FILTER_SIZE);

  logic                  pop_over;
  logic [2:0]            pop_clamp;
  logic [OUT_ADDR_W-1:0] step;
  logic [OUT_ADDR_W-1:0] addr_q, addr_d;
  logic                  err_q, err_d;

  // pop only counts while streaming; the flush beat always commits a full stride
  always_comb begin
    pop_over  = pop_i > POP_MAX;
    pop_clamp = pop_over ? POP_MAX : pop_i;
    step      = '0;
    if (flush_i) begin
      step = FLUSH_STEP;
    end else if (stream_i) begin
      step = OUT_ADDR_W'(pop_clamp);
    end
    out_we_o = flush_i | (stream_i & (pop_clamp != 3'd0));
    addr_d   = clear_i ? '0 : addr_q + step;
    err_d    = clear_i ? 1'b0 : (err_q | sat_err_i | (stream_i & pop_over));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign out_addr_o = addr_q;
  assign err_o      = err_q;

endmodule

// File: rtl/pe_row_scheduler.sv
// Frame sequencer for the PE row pipeline: loads weights, then walks the
// compressed input memory row by row, streaming entries and flushing each row.
module pe_row_scheduler
  import pe_pkg::*;
#(
  parameter int ROW_LEN     = ROW_LEN_DEF,
  parameter int FILTER_SIZE = FILTER_SIZE_DEF,
  parameter int NUM_ROWS    = 24,
  parameter int IN_ADDR_W   = 4,
  parameter int OUT_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  w_load_o,
  output logic [IN_ADDR_W-1:0]  w_addr_o,
  output logic                  in_rd_o,
  output logic [IN_ADDR_W-1:0]  in_addr_o,
  input  logic [15:0]           in_data_i,
  output logic                  pe_in_valid_o,
  output logic [15:0]           pe_in_o,
  output logic [4:0]            pe_cnt_o,
  input  logic [2:0]            pop_i,
  output logic                  out_we_o,
  output logic [OUT_ADDR_W-1:0] out_addr_o,
  output logic                  row_fini_o,
  output logic                  err_o
);

  localparam int               ROW_W    = $clog2(NUM_ROWS + 1);
  localparam logic [7:0]       ROW_LEN8 = 8'(ROW_LEN);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_e               state_q, state_d;
  logic [IN_ADDR_W-1:0] in_addr_q, in_addr_d;
  logic [4:0]           n_q, n_d;
  logic [4:0]           rd_q, rd_d;
  logic [4:0]           pe_cnt_q, pe_cnt_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [15:0]          pe_in_q;
  logic [7:0]           hdr_n;
  logic                 hdr_sat;
  logic [4:0]           n_cap;
  logic                 start_clr;

  assign hdr_n   = word_index(in_data_i);
  assign hdr_sat = hdr_n > ROW_LEN8;
  assign n_cap   = hdr_sat ? 5'(ROW_LEN) : hdr_n[4:0];

  // The first entry read overlaps the header capture cycle, so a row of N
  // entries costs exactly N+3 cycles; rd_q counts reads issued, pe_cnt_q beats.
  always_comb begin
    state_d   = state_q;
    in_addr_d = in_addr_q;
    n_d       = n_q;
    rd_d      = rd_q;
    pe_cnt_d  = pe_cnt_q;
    row_d     = row_q;
    in_rd_o   = 1'b0;
    start_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_clr = 1'b1;
          in_addr_d = '0;
          row_d     = '0;
          state_d   = S_WLOAD;
        end
      end
      S_WLOAD: state_d = S_HDR;
      S_HDR: begin
        in_rd_o   = 1'b1;
        in_addr_d = in_addr_q + IN_ADDR_W'(1);
        state_d   = S_HCAP;
      end
      S_HCAP: begin
        n_d      = n_cap;
        pe_cnt_d = 5'd1;
        if (n_cap == 5'd0) begin
          state_d = S_FLUSH;
        end else begin
          in_rd_o   = 1'b1;
          in_addr_d = in_addr_q + IN_ADDR_W'(1);
          rd_d      = 5'd1;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_q < n_q) begin
          in_rd_o   = 1'b1;
          in_addr_d = in_addr_q + IN_ADDR_W'(1);
          rd_d      = rd_q + 5'd1;
        end
        pe_cnt_d = pe_cnt_q + 5'd1;
        if (pe_cnt_q == n_q) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        row_d   = row_q + ROW_W'(1);
        state_d = (row_q == LAST_ROW) ? S_FIN : S_HDR;
      end
      S_FIN: begin
        pe_cnt_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_addr_q <= '0;
      n_q       <= '0;
      rd_q      <= '0;
      pe_cnt_q  <= '0;
      row_q     <= '0;
      pe_in_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_addr_q <= in_addr_d;
      n_q       <= n_d;
      rd_q      <= rd_d;
      pe_cnt_q  <= pe_cnt_d;
      row_q     <= row_d;
      if (pe_in_valid_o) begin
        pe_in_q <= pe_in_o;
      end
    end
  end

  // Read data arrives the cycle after in_rd, exactly when the beat is presented;
  // pe_in_q keeps the last beat visible between rows.
  assign pe_in_valid_o = (state_q == S_STREAM) || (state_q == S_FLUSH);
  assign pe_in_o       = (state_q == S_STREAM) ? in_data_i :
                         (state_q == S_FLUSH)  ? 16'd0     : pe_in_q;
  assign pe_cnt_o      = pe_cnt_q;
  assign busy_o        = state_q != S_IDLE;
  assign done_o        = state_q == S_FIN;
  assign w_load_o      = state_q == S_WLOAD;
  assign w_addr_o      = '0;
  assign in_addr_o     = in_addr_q;
  assign row_fini_o    = state_q == S_FLUSH;

  pe_row_scheduler_ptr #(
    .OUT_ADDR_W  (OUT_ADDR_W),
    .FILTER_SIZE (FILTER_SIZE)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (start_clr),
    .stream_i   (state_q == S_STREAM),
    .flush_i    (state_q == S_FLUSH),
    .sat_err_i  ((state_q == S_HCAP) && hdr_sat),
    .pop_i      (pop_i),
    .out_we_o   (out_we_o),
    .out_addr_o (out_addr_o),
    .err_o      (err_o)
  );

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Self-checking bench for pe_row_scheduler: a row-level schedule model predicts
// every output on every cycle of a frame; scenario tasks add targeted checks.
module tb_pe_row_scheduler;

  localparam int NROWS = 4;
  localparam int RLEN  = 28;
  localparam int FSIZE = 5;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wLoad;
    logic [3:0]  wAddr;
    logic        inRd;
    logic [3:0]  inAddr;
    logic        peValid;
    logic [15:0] peIn;
    logic [4:0]  peCnt;
    logic        outWe;
    logic [4:0]  outAddr;
    logic        rowFini;
    logic        err;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, wLoad, inRd, peValid, outWe, rowFini, err;
  logic [3:0]  wAddr, inAddr;
  logic [15:0] inData = '0;
  logic [15:0] peIn;
  logic [4:0]  peCnt, outAddr;
  logic [2:0]  pop;
  logic        memClr;

  int          nChecks = 0;
  int          nFails  = 0;
  int          hdrs [NROWS];
  logic [15:0] words [0:255];
  int          rdPtr = 0;
  outs_t       expTr[$];
  outs_t       obsTr[$];
  logic [2:0]  popTr[$];
  int          kindTr[$];
  int          mAddr, mOaddr, mHc;
  logic        mErr;
  logic [15:0] mHin;

  always #5 clk = ~clk;

  pe_row_scheduler #(
    .ROW_LEN     (RLEN),
    .FILTER_SIZE (FSIZE),
    .NUM_ROWS    (NROWS),
    .IN_ADDR_W   (4),
    .OUT_ADDR_W  (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .w_load_o      (wLoad),
    .w_addr_o      (wAddr),
    .in_rd_o       (inRd),
    .in_addr_o     (inAddr),
    .in_data_i     (inData),
    .pe_in_valid_o (peValid),
    .pe_in_o       (peIn),
    .pe_cnt_o      (peCnt),
    .pop_i         (pop),
    .out_we_o      (outWe),
    .out_addr_o    (outAddr),
    .row_fini_o    (rowFini),
    .err_o         (err)
  );

  // Input memory serves the frame's words in read order; addresses are checked separately.
  always @(posedge clk) begin
    if (memClr) begin
      rdPtr <= 0;
    end else if (inRd) begin
      inData <= words[rdPtr];
      rdPtr  <= rdPtr + 1;
    end
  end

  function automatic outs_t sample();
    outs_t s;
    s.busy = busy; s.done = done; s.wLoad = wLoad; s.wAddr = wAddr;
    s.inRd = inRd; s.inAddr = inAddr; s.peValid = peValid; s.peIn = peIn;
    s.peCnt = peCnt; s.outWe = outWe; s.outAddr = outAddr;
    s.rowFini = rowFini; s.err = err;
    return s;
  endfunction

  function automatic logic [2:0] genPop(input int mode, input int kind);
    if (mode == 0) return 3'd0;
    if (kind == 0) return 3'($urandom_range(0, 7));
    if (mode == 1) return 3'($urandom_range(0, 5));
    if (mode == 2) return 3'($urandom_range(0, 7));
    return (kind == 1) ? 3'd7 : 3'd2;
  endfunction

  function automatic int rowN(input int h);
    return (h > RLEN) ? RLEN : h;
  endfunction

  function automatic outs_t base();
    outs_t e = '0;
    e.busy = 1'b1; e.inAddr = 4'(mAddr); e.outAddr = 5'(mOaddr);
    e.err = mErr; e.peCnt = 5'(mHc); e.peIn = mHin;
    return e;
  endfunction

  task automatic pushCycle(input outs_t e, input logic [2:0] p, input int kind);
    expTr.push_back(e);
    popTr.push_back(p);
    kindTr.push_back(kind);
  endtask

  // Frame schedule: WLOAD, per row HDR + HCAP + N beats + flush, FIN, then IDLE.
  task automatic buildFrame(input int popMode);
    outs_t e;
    int w = 0;
    logic [2:0] p;
    int cl;
    expTr.delete(); popTr.delete(); kindTr.delete();
    for (int r = 0; r < NROWS; r++) begin
      words[w] = {8'(hdrs[r]), 8'($urandom)};
      w++;
      for (int k = 0; k < rowN(hdrs[r]); k++) begin
        words[w] = 16'($urandom);
        w++;
      end
    end
    mAddr = 0; mOaddr = 0; mErr = 1'b0; mHc = 0; mHin = '0; w = 0;
    e = base(); e.wLoad = 1'b1;
    pushCycle(e, genPop(popMode, 0), 0);
    for (int r = 0; r < NROWS; r++) begin
      int n = rowN(hdrs[r]);
      e = base(); e.inRd = 1'b1;
      pushCycle(e, genPop(popMode, 0), 0);
      mAddr++; w++;
      e = base(); e.inRd = (n > 0);
      pushCycle(e, genPop(popMode, 0), 0);
      if (n > 0) mAddr++;
      if (hdrs[r] > RLEN) mErr = 1'b1;
      for (int k = 1; k <= n; k++) begin
        p = genPop(popMode, (k == 1) ? 1 : 2);
        cl = (int'(p) > FSIZE) ? FSIZE : int'(p);
        e = base();
        e.peValid = 1'b1; e.peIn = words[w]; e.peCnt = 5'(k);
        e.inRd = (k < n); e.outWe = (cl != 0);
        pushCycle(e, p, 1);
        mHin = words[w]; mHc = k; w++;
        if (k < n) mAddr++;
        mOaddr += cl;
        if (int'(p) > FSIZE) mErr = 1'b1;
      end
      e = base();
      e.peValid = 1'b1; e.peIn = '0; e.peCnt = 5'(n + 1);
      e.rowFini = 1'b1; e.outWe = 1'b1;
      pushCycle(e, genPop(popMode, 0), 0);
      mOaddr += FSIZE; mHc = n + 1; mHin = '0;
    end
    e = base(); e.done = 1'b1;
    pushCycle(e, genPop(popMode, 0), 0);
    mHc = 0;
    e = base(); e.busy = 1'b0;
    pushCycle(e, genPop(popMode, 0), 0);
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_frame(input int popMode, input bit pulseStart);
    buildFrame(popMode);
    obsTr.delete();
    memClr = 1'b1; start = 1'b1; pop = 3'd0;
    @(posedge clk); #1;
    memClr = 1'b0; start = 1'b0;
    for (int i = 0; i < expTr.size(); i++) begin
      pop   = popTr[i];
      start = pulseStart && (kindTr[i] == 1);
      @(negedge clk);
      obsTr.push_back(sample());
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nChecks++;
    if (sample() !== outs_t'(0)) begin
      nFails++;
      $display("[TB] FAIL reset_hold got %h exp %h", sample(), outs_t'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    nChecks++;
    if (sample() !== outs_t'(0)) begin
      nFails++;
      $display("[TB] FAIL reset_idle got %h exp %h", sample(), outs_t'(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_row();
    hdrs = '{3, 0, 0, 0};
    run_frame(0, 1'b0);
    for (int i = 0; i < expTr.size(); i++) begin
      nChecks++;
      if (obsTr[i] !== expTr[i]) begin
        nFails++;
        $display("[TB] FAIL single_row cyc %0d got %h exp %h", i, obsTr[i], expTr[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (obsTr[2 + i].inRd !== 1'b1 || obsTr[2 + i].inAddr !== 4'(i + 1)) begin
        nFails++;
        $display("[TB] FAIL single_row_rd cyc %0d got rd %b addr %0d exp rd 1 addr %0d",
                 2 + i, obsTr[2 + i].inRd, obsTr[2 + i].inAddr, i + 1);
      end
    end
    nChecks++;
    if (obsTr[6].rowFini !== 1'b1 || obsTr[6].peCnt !== 5'd4) begin
      nFails++;
      $display("[TB] FAIL single_row_flush got fini %b cnt %0d exp fini 1 cnt 4",
               obsTr[6].rowFini, obsTr[6].peCnt);
    end
    nChecks++;
    if (obsTr[7].outAddr !== 5'd5) begin
      nFails++;
      $display("[TB] FAIL single_row_oaddr got %0d exp 5", obsTr[7].outAddr);
    end
    nChecks++;
    if (obsTr[16].done !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL single_row_done got %b exp 1", obsTr[16].done);
    end
  endtask

  task automatic test_empty_rows();
    hdrs = '{0, 0, 0, 0};
    run_frame(1, 1'b0);
    for (int i = 0; i < expTr.size(); i++) begin
      nChecks++;
      if (obsTr[i] !== expTr[i]) begin
        nFails++;
        $display("[TB] FAIL empty_rows cyc %0d got %h exp %h", i, obsTr[i], expTr[i]);
      end
    end
    for (int r = 0; r < NROWS; r++) begin
      nChecks++;
      if (obsTr[3 + 3 * r].rowFini !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL empty_rows_fini row %0d got %b exp 1", r, obsTr[3 + 3 * r].rowFini);
      end
    end
    nChecks++;
    if (obsTr[13].done !== 1'b1 || obsTr[14].outAddr !== 5'd20) begin
      nFails++;
      $display("[TB] FAIL empty_rows_end got done %b oaddr %0d exp done 1 oaddr 20",
               obsTr[13].done, obsTr[14].outAddr);
    end
  endtask

  task automatic test_pop_clamp();
    hdrs = '{4, 0, 0, 0};
    run_frame(3, 1'b0);
    for (int i = 0; i < expTr.size(); i++) begin
      nChecks++;
      if (obsTr[i] !== expTr[i]) begin
        nFails++;
        $display("[TB] FAIL pop_clamp cyc %0d got %h exp %h", i, obsTr[i], expTr[i]);
      end
    end
    nChecks++;
    if (obsTr[4].outAddr !== 5'd5 || obsTr[6].outAddr !== 5'd9) begin
      nFails++;
      $display("[TB] FAIL pop_clamp_addr got %0d,%0d exp 5,9", obsTr[4].outAddr, obsTr[6].outAddr);
    end
    nChecks++;
    if (obsTr[3].err !== 1'b0 || obsTr[4].err !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL pop_clamp_err got %b,%b exp 0,1", obsTr[3].err, obsTr[4].err);
    end
  endtask

  task automatic test_saturation();
    int reads = 0;
    int expReads = 0;
    hdrs = '{40, 2, 0, 1};
    run_frame(0, 1'b0);
    for (int i = 0; i < expTr.size(); i++) begin
      nChecks++;
      if (obsTr[i] !== expTr[i]) begin
        nFails++;
        $display("[TB] FAIL saturation cyc %0d got %h exp %h", i, obsTr[i], expTr[i]);
      end
      if (obsTr[i].inRd === 1'b1) reads++;
    end
    for (int r = 0; r < NROWS; r++) expReads += 1 + rowN(hdrs[r]);
    nChecks++;
    if (reads != expReads || obsTr[obsTr.size() - 1].err !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL saturation_reads got %0d err %b exp %0d err 1",
               reads, obsTr[obsTr.size() - 1].err, expReads);
    end
  endtask

  task automatic test_wrap();
    hdrs = '{12, 12, 12, 12};
    run_frame(1, 1'b0);
    for (int i = 0; i < expTr.size(); i++) begin
      nChecks++;
      if (obsTr[i] !== expTr[i]) begin
        nFails++;
        $display("[TB] FAIL wrap cyc %0d got %h exp %h", i, obsTr[i], expTr[i]);
      end
    end
    for (int i = 0; i + 1 < obsTr.size(); i++) begin
      if (obsTr[i].inRd === 1'b1 && obsTr[i].inAddr === 4'd15) begin
        nChecks++;
        if (obsTr[i + 1].inRd !== 1'b1 || obsTr[i + 1].inAddr !== 4'd0) begin
          nFails++;
          $display("[TB] FAIL wrap_next cyc %0d got rd %b addr %0d exp rd 1 addr 0",
                   i + 1, obsTr[i + 1].inRd, obsTr[i + 1].inAddr);
        end
      end
    end
    nChecks++;
    if (obsTr[obsTr.size() - 1].inAddr !== 4'd4) begin
      nFails++;
      $display("[TB] FAIL wrap_final got %0d exp 4", obsTr[obsTr.size() - 1].inAddr);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < NROWS; r++) hdrs[r] = $urandom_range(0, 31);
      run_frame($urandom_range(1, 2), 1'b0);
      for (int i = 0; i < expTr.size(); i++) begin
        nChecks++;
        if (obsTr[i] !== expTr[i]) begin
          nFails++;
          $display("[TB] FAIL random f%0d cyc %0d got %h exp %h", f, i, obsTr[i], expTr[i]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    hdrs = '{6, 3, 0, 5};
    run_frame(1, 1'b1);
    for (int i = 0; i < expTr.size(); i++) begin
      nChecks++;
      if (obsTr[i] !== expTr[i]) begin
        nFails++;
        $display("[TB] FAIL start_ignored cyc %0d got %h exp %h", i, obsTr[i], expTr[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    hdrs = '{10, 4, 4, 4};
    buildFrame(2);
    memClr = 1'b1; start = 1'b1; pop = 3'd0;
    @(posedge clk); #1;
    memClr = 1'b0; start = 1'b0; pop = 3'd3;
    repeat (4) @(posedge clk);
    #1;
    nChecks++;
    if (peValid !== 1'b1 || peCnt !== 5'd2) begin
      nFails++;
      $display("[TB] FAIL mid_stream_pre got valid %b cnt %0d exp valid 1 cnt 2", peValid, peCnt);
    end
    rst = 1'b1;
    #1;
    nChecks++;
    if (sample() !== outs_t'(0)) begin
      nFails++;
      $display("[TB] FAIL mid_stream_rst got %h exp %h", sample(), outs_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nChecks++;
      if (sample() !== outs_t'(0)) begin
        nFails++;
        $display("[TB] FAIL mid_stream_after got %h exp %h", sample(), outs_t'(0));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < NROWS; r++) hdrs[r] = $urandom_range(0, 9);
      run_frame(2, 1'b0);
      for (int i = 0; i < expTr.size(); i++) begin
        nChecks++;
        if (obsTr[i] !== expTr[i]) begin
          nFails++;
          $display("[TB] FAIL back_to_back f%0d cyc %0d got %h exp %h", f, i, obsTr[i], expTr[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pop = 3'd0; memClr = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_row();
    test_empty_rows();
    test_pop_clamp();
    test_saturation();
    test_wrap();
    test_random();
    test_start_ignored();
    test_reset_mid_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
